// File: rtl/conv_pkg.sv
// Shared types, default widths and the scale/saturate helper for conv_window_mac.
package conv_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_FRAC_W = 11;

    // Working width of sat_shift; every supported accumulator must fit inside it.
    localparam int SAT_ACC_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_e;

    // Arithmetic shift (truncation toward -inf), then clamp to a data_w-bit signed range.
    function automatic logic signed [SAT_ACC_W-1:0] sat_shift(
        input logic signed [SAT_ACC_W-1:0] acc,
        input int                          data_w,
        input int                          frac_w
    );
        logic signed [SAT_ACC_W-1:0] shifted;
        logic signed [SAT_ACC_W-1:0] max_v;
        logic signed [SAT_ACC_W-1:0] min_v;
        shifted = acc >>> frac_w;
        max_v   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v   = -max_v - 64'sd1;
        if (shifted > max_v) begin
            return max_v;
        end else if (shifted < min_v) begin
            return min_v;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/conv_lane_group.sv
// Combinational LANES-wide signed multiplier row and adder tree for one group of
// window/filter elements; elements past the end of the window read as zero.
module conv_lane_group #(
    parameter int DATA_W   = 16,
    parameter int NUM_ELEM = 25,
    parameter int LANES    = 5,
    parameter int N_GROUPS = 5,
    parameter int GRP_W    = 3,
    parameter int SUM_W    = 37
) (
    input  logic [DATA_W*NUM_ELEM-1:0] window_i,
    input  logic [DATA_W*NUM_ELEM-1:0] filter_i,
    input  logic [GRP_W-1:0]           group_i,
    output logic signed [SUM_W-1:0]    sum_o
);
    localparam int PAD    = N_GROUPS * LANES;
    localparam int IDX_W  = (PAD > 1) ? $clog2(PAD) : 1;
    localparam int PROD_W = 2 * DATA_W;

    logic signed [DATA_W-1:0] win_a  [PAD];
    logic signed [DATA_W-1:0] flt_a  [PAD];
    logic signed [PROD_W-1:0] prod_a [LANES];

    for (genvar e = 0; e < PAD; e++) begin : g_unpack
        if (e < NUM_ELEM) begin : g_real
            assign win_a[e] = window_i[e*DATA_W +: DATA_W];
            assign flt_a[e] = filter_i[e*DATA_W +: DATA_W];
        end else begin : g_pad
            assign win_a[e] = '0;
            assign flt_a[e] = '0;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IDX_W-1:0] idx;
        assign idx       = IDX_W'(group_i) * IDX_W'(LANES) + IDX_W'(l);
        assign prod_a[l] = PROD_W'(win_a[idx]) * PROD_W'(flt_a[idx]);
    end

    always_comb begin
        // NOTE: sum_o gets its default before the loop so no path leaves it unassigned (no latch).
        sum_o = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_o = sum_o + SUM_W'(prod_a[l]);
        end
    end

endmodule

// File: rtl/conv_window_mac.sv
// Sequential KxK window/filter MAC: LANES products per cycle, full-precision accumulate,
// then shift and saturate to DATA_W. Optional fused ReLU under CONV_WINDOW_RELU_EN.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int FRAC_W = DEFAULT_FRAC_W,
    parameter int K      = 5,
    parameter int LANES  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W*K*K-1:0] window_flat,
    input  logic [DATA_W*K*K-1:0] filter_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_value
);
    localparam int NUM_ELEM = K * K;
    localparam int N_GROUPS = (NUM_ELEM + LANES - 1) / LANES;
    localparam int GRP_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int ACC_W    = 2 * DATA_W + $clog2(NUM_ELEM);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(N_GROUPS - 1);

    state_e                     state_q;
    logic                       in_ready_q;
    logic                       out_valid_q;
    logic [DATA_W-1:0]          out_value_q;
    logic [GRP_W-1:0]           grp_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    group_sum;
    logic [DATA_W*NUM_ELEM-1:0] window_q;
    logic [DATA_W*NUM_ELEM-1:0] filter_q;
    logic signed [DATA_W-1:0]   sat_value;
    logic [DATA_W-1:0]          result_d;

    conv_lane_group #(
        .DATA_W   (DATA_W),
        .NUM_ELEM (NUM_ELEM),
        .LANES    (LANES),
        .N_GROUPS (N_GROUPS),
        .GRP_W    (GRP_W),
        .SUM_W    (ACC_W)
    ) u_lanes (
        .window_i (window_q),
        .filter_i (filter_q),
        .group_i  (grp_q),
        .sum_o    (group_sum)
    );

    assign acc_d     = acc_q + group_sum;
    assign sat_value = DATA_W'(sat_shift(SAT_ACC_W'(acc_d), DATA_W, FRAC_W));

`ifdef CONV_WINDOW_RELU_EN
    assign result_d = sat_value[DATA_W-1] ? '0 : sat_value;
`else
    assign result_d = sat_value;
`endif

    // NOTE: operand registers carry no reset; they are only read after a capture overwrites them.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready_q) begin
            window_q <= window_flat;
            filter_q <= filter_flat;
        end
    end

    // NOTE: every state register uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            acc_q       <= '0;
            grp_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        acc_q      <= '0;
                        grp_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    grp_q <= grp_q + GRP_W'(1);
                    if (grp_q == GRP_LAST) begin
                        out_value_q <= result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_value = out_value_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac at LANES = 5, 3 (padded last group) and 25.
module tb_conv_window_mac;

    localparam int DW   = 16;
    localparam int KK   = 25;
    localparam int NI   = 3;
    localparam int N_OF [NI] = '{5, 9, 1};

    logic              clk = 1'b0;
    logic              rst;
    logic [DW*KK-1:0]  window_flat;
    logic [DW*KK-1:0]  filter_flat;
    logic              in_valid  [NI];
    logic              in_ready  [NI];
    logic              out_valid [NI];
    logic              out_ready [NI];
    logic [DW-1:0]     out_value [NI];

    logic [DW-1:0]     exp_q[$];
    int                n_assert = 0;
    int                n_fail   = 0;

    always #5 clk = ~clk;

    conv_window_mac #(.LANES(5)) u_l5 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .window_flat(window_flat), .filter_flat(filter_flat),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_value(out_value[0])
    );
    conv_window_mac #(.LANES(3)) u_l3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .window_flat(window_flat), .filter_flat(filter_flat),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_value(out_value[1])
    );
    conv_window_mac #(.LANES(25)) u_l25 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .window_flat(window_flat), .filter_flat(filter_flat),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_value(out_value[2])
    );

    function automatic logic [DW-1:0] golden(input logic [DW*KK-1:0] w, input logic [DW*KK-1:0] f);
        longint acc = 0;
        for (int e = 0; e < KK; e++) begin
            acc += longint'($signed(w[e*DW +: DW])) * longint'($signed(f[e*DW +: DW]));
        end
        acc = acc >>> 11;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`ifdef CONV_WINDOW_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc[DW-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill_all(input logic [DW-1:0] wv, input logic [DW-1:0] fv);
        for (int e = 0; e < KK; e++) begin
            window_flat[e*DW +: DW] = wv;
            filter_flat[e*DW +: DW] = fv;
        end
    endtask

    task automatic fill_rand();
        for (int e = 0; e < KK; e++) begin
            window_flat[e*DW +: DW] = DW'($urandom_range(0, 65535));
            filter_flat[e*DW +: DW] = DW'($urandom_range(0, 4095)) - 16'd2048;
        end
    endtask

    // Presents the current pair (in_ready assumed high) and counts edges until out_valid.
    task automatic send(input int s, input string tag, output int lat);
        check({tag, " in_ready before"}, 32'(in_ready[s]), 32'd1);
        in_valid[s] = 1'b1;
        @(negedge clk);
        in_valid[s] = 1'b0;
        lat = 1;
        while (!out_valid[s] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take(input int s, input string tag);
        logic [DW-1:0] e;
        check({tag, " out_valid"}, 32'(out_valid[s]), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, " value"}, 32'(out_value[s]), 32'(e));
        out_ready[s] = 1'b1;
        @(negedge clk);
        out_ready[s] = 1'b0;
        check({tag, " in_ready after"}, 32'(in_ready[s]), 32'd1);
        check({tag, " out_valid after"}, 32'(out_valid[s]), 32'd0);
    endtask

    task automatic run(input int s, input string tag, input logic [DW-1:0] expv, input int exp_lat);
        int lat;
        exp_q.push_back(expv);
        send(s, tag, lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        take(s, tag);
    endtask

    task automatic check_reset_state(input int s, input string tag);
        check({tag, " in_ready"}, 32'(in_ready[s]), 32'd1);
        check({tag, " out_valid"}, 32'(out_valid[s]), 32'd0);
        check({tag, " out_value"}, 32'(out_value[s]), 32'd0);
    endtask

    initial begin
        int lat;
        logic [DW-1:0] neg_exp;
        rst = 1'b1;
        for (int s = 0; s < NI; s++) begin
            in_valid[s]  = 1'b0;
            out_ready[s] = 1'b0;
        end
        fill_all(16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < NI; s++) check_reset_state(s, $sformatf("reset inst%0d", s));

        // Constant windows: in-range, positive overflow, negative overflow.
        fill_all(16'h0400, 16'h0800);
        run(0, "half", 16'h6400, 6);
        fill_all(16'h0800, 16'h0800);
        run(0, "pos_sat", 16'h7FFF, 6);
`ifdef CONV_WINDOW_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'h8000;
`endif
        fill_all(16'hF800, 16'h0800);
        run(0, "neg_sat", neg_exp, 6);

        // Ramp window with a single unit tap at (2,3) selects element 13.
        fill_all(16'h0000, 16'h0000);
        for (int e = 0; e < KK; e++) window_flat[e*DW +: DW] = DW'(e);
        filter_flat[13*DW +: DW] = 16'h0800;
        run(0, "tap_l5", 16'd13, 6);
        run(1, "tap_l3", 16'd13, 10);
        run(2, "tap_l25", 16'd13, 2);

        // Backpressure: result held, in_ready low, a competing pair is ignored.
        fill_all(16'h0400, 16'h0800);
        exp_q.push_back(16'h6400);
        send(0, "bp", lat);
        check("bp latency", 32'(lat), 32'd6);
        fill_all(16'h0800, 16'h0800);
        in_valid[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp hold%0d valid", c), 32'(out_valid[0]), 32'd1);
            check($sformatf("bp hold%0d value", c), 32'(out_value[0]), 32'h6400);
            check($sformatf("bp hold%0d in_ready", c), 32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        take(0, "bp");
        repeat (8) @(negedge clk);
        check("bp no extra result", 32'(out_valid[0]), 32'd0);

        // Reset while MAC group 2 is in flight, then a clean pair.
        fill_all(16'h0800, 16'h0800);
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state(0, "rst_mac");
        fill_all(16'h0400, 16'h0800);
        run(0, "after_rst", 16'h6400, 6);

        // Reset with a result pending in DONE.
        send(0, "rst_done", lat);
        check("rst_done pending", 32'(out_valid[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state(0, "rst_done");

        // Back-to-back random pairs with in_valid held high; inputs change after each capture.
        for (int s = 0; s < NI; s++) begin
            int got = 0;
            int accepted = 0;
            int cyc = 0;
            int last_acc = 0;
            bit just_acc = 1'b0;
            exp_q.delete();
            fill_rand();
            out_ready[s] = 1'b1;
            in_valid[s]  = 1'b1;
            while (got < 4 && cyc < 400) begin
                if (just_acc) fill_rand();
                just_acc = 1'b0;
                if (out_valid[s]) begin
                    check($sformatf("b2b inst%0d res%0d", s, got), 32'(out_value[s]),
                          32'((exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx));
                    got++;
                end
                if (in_valid[s] && in_ready[s]) begin
                    if (accepted > 0)
                        check($sformatf("b2b inst%0d spacing", s), 32'(cyc - last_acc), 32'(N_OF[s] + 2));
                    last_acc = cyc;
                    accepted++;
                    exp_q.push_back(golden(window_flat, filter_flat));
                    just_acc = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
            in_valid[s] = 1'b0;
            check($sformatf("b2b inst%0d results", s), 32'(got), 32'd4);
            @(negedge clk);
            out_ready[s] = 1'b0;
            check($sformatf("b2b inst%0d idle", s), 32'(in_ready[s]), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
